fifo_wr_arb: RTL and testbench
==============================

// Module: fifo_wr_arb
// PURPOSE
//  Round-robin write-side arbiter sharing one async FIFO write port among NREQ requesters.
//  Sits in the wclk domain ahead of the FIFO: drives wdata/winc, honours wfull.
//  Grants in bursts of up to BURST words for fairness with low switching overhead.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  DSIZE  8  data width; equals FIFO DSIZE
//  BURST  4  max words per grant (1..16)
// PORTS
//  wclk       in   1           write-domain clock; all logic on rising edge
//  wrst       in   1           synchronous, active-high reset
//  req_valid  in   NREQ        requester i has a word on its slice of req_data
//  req_data   in   NREQ*DSIZE  requester i data at [i*DSIZE +: DSIZE]
//  req_ready  out  NREQ        word of requester i accepted this cycle when req_valid[i] is also high
//  wfull      in   1           FIFO full flag (registered by the FIFO)
//  wdata      out  DSIZE       FIFO write data
//  winc       out  1           FIFO write enable
//  gnt        out  NREQ        registered one-hot grant; all-zero when idle
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, ptr=NREQ-1 (requester 0 wins first), cnt=0.
//    Outputs during reset: winc=0, req_ready=0, wdata=0.
//  - FSM states: IDLE, GRANT.
//  - IDLE, any req_valid high:
//    - select the first valid index searching ptr+1, ptr+2, ... modulo NREQ;
//    - register gnt one-hot, cnt<=0, go to GRANT.
//    - The arbitration bubble is exactly 1 cycle; no writes occur in IDLE.
//  - IDLE, no req_valid: stay in IDLE.
//  - GRANT, with g = granted index:
//    - req_ready[g] = ~wfull; req_ready of all other requesters = 0;
//    - winc = req_valid[g] & ~wfull;
//    - wdata = req_data slice g (combinational mux from the registered gnt).
//  - GRANT, transfer (winc=1):
//    - if cnt==BURST-1, release;
//    - otherwise cnt<=cnt+1 and stay in GRANT.
//  - GRANT, req_valid[g]=0: release in the same cycle; nothing is written.
//  - GRANT, wfull=1 with req_valid[g]=1: stall. Stay in GRANT with cnt held; no timeout.
//  - Release: gnt<=0, ptr<=g, go to IDLE. Re-arbitration starts after g, so a
//    continuous requester yields to the others after BURST words.
//  - Single requester streaming: BURST words, 1-cycle bubble, repeat.
//    Sustained throughput is BURST/(BURST+1).
//  - The FIFO never receives winc while wfull=1. winc is never asserted with gnt=0.
//  - Mid-operation reset: immediate return to reset state; a partial burst is abandoned;
//    no winc in the reset cycle.
//  - cnt width is clog2(BURST) (min 1); ptr width is clog2(NREQ).
// CONFIGURATION
//  - Macro ARB_STATS_EN defined: adds two ports.
//    - stat_clr in 1: synchronous clear of all counters, higher priority than increments.
//    - stat_cnt out NREQ*16: per-requester count of accepted words.
//      Counter i is at [i*16 +: 16]; counters saturate at 16'hFFFF; reset to 0.
//  - Macro not defined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset: hold wrst 2 cycles with all req_valid=1.
//     -> winc=0 and gnt=0 during reset; first grant after release is gnt=4'b0001.
//  2. Round robin: req_valid=4'b1111 steady, BURST=4, wfull=0.
//     -> 4 words each from req 0,1,2,3,0; 1 idle cycle between bursts; wdata matches source.
//  3. Early release: req 2 drops valid after 2 words while req 3 is valid.
//     -> release in that cycle; next gnt=4'b1000; exactly 2 words from req 2.
//  4. Full stall: assert wfull for 5 cycles mid-burst (cnt=1).
//     -> winc=0 and req_ready=0 throughout; burst resumes; 4 words total; none lost or duplicated.
//  5. Mid-burst reset: wrst at cnt=2.
//     -> gnt=0 next cycle; ptr reset, so req 0 is granted first afterwards.
//  6. ARB_STATS_EN: 10 words from req 1, then stat_clr for 1 cycle.
//     -> stat_cnt[31:16]=10 before the clear, 0 after; other counters stay 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NREQ requesters (wclk domain).
// Optional per-requester accepted-word counters are enabled with `define ARB_STATS_EN.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic [DSIZE-1:0]        wdata,
    output logic                    winc,
    output logic [NREQ-1:0]         gnt
`ifdef ARB_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [NREQ*16-1:0]      stat_cnt
`endif
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int PW = $clog2(NREQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_p0, state_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [PW-1:0]   gidx_p0, gidx_nxt;
    logic [PW-1:0]   ptr_p0, ptr_nxt;
    logic [CW-1:0]   cnt_p0, cnt_nxt;
    logic [PW-1:0]   sel;
    logic            sel_vld;
    logic            rel;
    logic            active;

    // Walk from the farthest candidate to the nearest so the first valid after ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr_p0) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx[PW-1:0]]) begin
                sel     = idx[PW-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state_p0;
        gnt_nxt   = gnt;
        gidx_nxt  = gidx_p0;
        ptr_nxt   = ptr_p0;
        cnt_nxt   = cnt_p0;
        rel       = 1'b0;
        case (state_p0)
            IDLE: begin
                if (sel_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NREQ'(1) << sel;
                    gidx_nxt  = sel;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req_valid[gidx_p0]) begin
                    rel = 1'b1;
                end else if (!wfull) begin
                    if (cnt_p0 == CNT_LAST) rel = 1'b1;
                    else                    cnt_nxt = cnt_p0 + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rel) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            ptr_nxt   = gidx_p0;
        end
    end

    // Write port is driven combinationally from the registered grant; forced quiet in reset.
    always_comb begin
        active    = (state_p0 == GRANT) && !wrst;
        winc      = active && req_valid[gidx_p0] && !wfull;
        req_ready = (active && !wfull) ? gnt : '0;
        wdata     = active ? req_data[gidx_p0*DSIZE +: DSIZE] : '0;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_p0 <= IDLE;
            gnt      <= '0;
            gidx_p0  <= '0;
            ptr_p0   <= PW'(NREQ - 1);
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            gnt      <= gnt_nxt;
            gidx_p0  <= gidx_nxt;
            ptr_p0   <= ptr_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

`ifdef ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stat_p0 [NREQ];

    always_ff @(posedge wclk) begin
        if (wrst || stat_clr) begin
            for (int i = 0; i < NREQ; i++) stat_p0[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (winc && gnt[i]) stat_p0[i] <= sat_inc(stat_p0[i]);
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) stat_cnt[i*16 +: 16] = stat_p0[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic against a word-counting reference model.
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull = 1'b0;
    logic [DSIZE-1:0]      wdata;
    logic                  winc;
    logic [NREQ-1:0]       gnt;
`ifdef ARB_STATS_EN
    logic                  stat_clr = 1'b0;
    logic [NREQ*16-1:0]    stat_cnt;
`endif

    fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .wclk(wclk), .wrst(wrst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .wfull(wfull), .wdata(wdata), .winc(winc), .gnt(gnt)
`ifdef ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: current owner (-1 = none), words sent in this burst, last owner served.
    int owner = -1;
    int last  = NREQ - 1;
    int sent  = 0;
    int obs_cnt  [NREQ];
    int exp_stat [NREQ];

    task automatic clear_counts();
        for (int i = 0; i < NREQ; i++) obs_cnt[i] = 0;
    endtask

    task automatic tick();
        logic [NREQ-1:0]  e_gnt;
        logic [NREQ-1:0]  e_ready;
        logic [DSIZE-1:0] e_wdata;
        logic             e_winc;
        bit               act;
        #4;
        e_gnt = '0;
        e_ready = '0;
        e_wdata = '0;
        e_winc = 1'b0;
        act = (!wrst && owner >= 0);
        if (owner >= 0) e_gnt[owner] = 1'b1;
        if (act) begin
            e_wdata = req_data[owner*DSIZE +: DSIZE];
            e_winc  = req_valid[owner] && !wfull;
            if (!wfull) e_ready = e_gnt;
        end
        chk("gnt", gnt, e_gnt);
        chk("winc", winc, e_winc);
        chk("req_ready", req_ready, e_ready);
        chk("wdata", wdata, e_wdata);
`ifdef ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("stat_cnt", stat_cnt[i*16 +: 16], exp_stat[i]);
`endif
        for (int i = 0; i < NREQ; i++) if (winc && gnt[i]) obs_cnt[i]++;
        @(posedge wclk);
`ifdef ARB_STATS_EN
        if (wrst || stat_clr) begin
            for (int i = 0; i < NREQ; i++) exp_stat[i] = 0;
        end else if (e_winc && exp_stat[owner] < 65535) begin
            exp_stat[owner]++;
        end
`endif
        if (wrst) begin
            owner = -1;
            last  = NREQ - 1;
            sent  = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int cand;
                cand = (last + k) % NREQ;
                if (owner < 0 && req_valid[cand]) begin
                    owner = cand;
                    sent  = 0;
                end
            end
        end else if (!req_valid[owner]) begin
            last  = owner;
            owner = -1;
        end else if (!wfull) begin
            sent++;
            if (sent == BURST) begin
                last  = owner;
                owner = -1;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            req_data = $urandom;
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        wrst = 1'b1;
        run(n);
        wrst = 1'b0;
        clear_counts();
    endtask

    initial begin
        clear_counts();
        for (int i = 0; i < NREQ; i++) exp_stat[i] = 0;

        // Reset held two cycles with every requester asking
        wrst = 1'b1;
        req_valid = '1;
        @(posedge wclk);
        #1;
        run(1);
        wrst = 1'b0;
        run(1);
        chk("t1_first_gnt", gnt, 4'b0001);

        // Steady round robin
        do_reset(1);
        req_valid = '1;
        wfull = 1'b0;
        run(25);
        chk("t2_words_r0", obs_cnt[0], 8);
        chk("t2_words_r1", obs_cnt[1], 4);
        chk("t2_words_r2", obs_cnt[2], 4);
        chk("t2_words_r3", obs_cnt[3], 4);

        // Early release when the owner drops valid
        do_reset(1);
        req_valid = 4'b1100;
        run(3);
        req_valid = 4'b1000;
        run(1);
        chk("t3_release", gnt, 4'b0000);
        run(1);
        chk("t3_next_gnt", gnt, 4'b1000);
        chk("t3_req2_words", obs_cnt[2], 2);
        req_valid = '0;
        run(6);

        // Full stall mid-burst
        do_reset(1);
        req_valid = 4'b0001;
        run(2);
        wfull = 1'b1;
        run(5);
        chk("t4_stalled_words", obs_cnt[0], 1);
        wfull = 1'b0;
        run(3);
        req_valid = '0;
        run(2);
        chk("t4_words", obs_cnt[0], 4);

        // Reset in the middle of req 1's burst
        do_reset(1);
        req_valid = '1;
        run(8);
        wrst = 1'b1;
        run(1);
        chk("t5_gnt_after_rst", gnt, 4'b0000);
        wrst = 1'b0;
        run(1);
        chk("t5_first_gnt", gnt, 4'b0001);
        req_valid = '0;
        run(6);

`ifdef ARB_STATS_EN
        do_reset(1);
        req_valid = 4'b0010;
        for (int c = 0; c < 40 && obs_cnt[1] < 10; c++) run(1);
        req_valid = '0;
        run(1);
        chk("t6_words", obs_cnt[1], 10);
        chk("t6_stat1", stat_cnt[31:16], 10);
        chk("t6_stat0", stat_cnt[15:0], 0);
        chk("t6_stat3", stat_cnt[63:48], 0);
        stat_clr = 1'b1;
        run(1);
        stat_clr = 1'b0;
        chk("t6_stat1_clr", stat_cnt[31:16], 0);
`endif

        // Random traffic, back-pressure and occasional reset
        do_reset(1);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(9) < 7);
            wfull = ($urandom_range(3) == 0);
            wrst  = ($urandom_range(99) == 0);
`ifdef ARB_STATS_EN
            stat_clr = ($urandom_range(199) == 0);
`endif
            run(1);
        end
        wrst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
